// File: rtl/shift_sched_pkg.sv
// Shared constants, op encodings and shift-amount helper for the shift scheduler.
package shift_sched_pkg;

  localparam int NPORT = 2;
  localparam int AMT_W = 5;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OP_ASR  = 2'b00,
    OP_LSR  = 2'b01,
    OP_LSL  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  // A zero register amount means "immediate plus one"; all sums wrap at 32.
  function automatic logic [AMT_W-1:0] shift_amount(input logic [AMT_W-1:0] v2_lo,
                                                     input logic [3:0]       hex);
    logic [AMT_W-1:0] hex_w;
    hex_w = AMT_W'(hex);
    if (v2_lo == '0) begin
      return hex_w + AMT_W'(1);
    end else begin
      return v2_lo + hex_w;
    end
  endfunction

endpackage

// File: rtl/shift_sched_if.sv
// Request/response bundle between the requesters, the scheduler and the result consumer.
interface shift_sched_if;
  import shift_sched_pkg::*;

  logic [NPORT-1:0]  req_valid;
  logic [NPORT-1:0]  req_ready;
  logic [1:0]        req_op0;
  logic [1:0]        req_op1;
  logic [DATA_W-1:0] req_value1_0;
  logic [DATA_W-1:0] req_value1_1;
  logic [DATA_W-1:0] req_value2_0;
  logic [DATA_W-1:0] req_value2_1;
  logic [3:0]        req_hex0;
  logic [3:0]        req_hex1;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_port;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_op0, req_op1, req_value1_0, req_value1_1,
           req_value2_0, req_value2_1, req_hex0, req_hex1, rsp_ready,
    input  req_ready, rsp_valid, rsp_port, rsp_data
  );

  modport slave (
    input  req_valid, req_op0, req_op1, req_value1_0, req_value1_1,
           req_value2_0, req_value2_1, req_hex0, req_hex1, rsp_ready,
    output req_ready, rsp_valid, rsp_port, rsp_data
  );

endinterface

// File: rtl/shift_core.sv
// Combinational shifter: ASR/LSR/LSL/pass with wrapped 5-bit amount and oversize zeroing.
module shift_core
  import shift_sched_pkg::*;
(
  input  op_e               op_i,
  input  logic [DATA_W-1:0] value1_i,
  input  logic [DATA_W-1:0] value2_i,
  input  logic [3:0]        hex_i,
  output logic [DATA_W-1:0] result_o
);

  logic [AMT_W-1:0] amt_s;
  logic             oversize_s;

  // Any register amount of 32 or more zeroes every real shift.
  always_comb begin
    amt_s      = shift_amount(value2_i[AMT_W-1:0], hex_i);
    oversize_s = |value2_i[DATA_W-1:AMT_W];
    result_o   = value1_i;
    case (op_i)
      OP_ASR:  result_o = oversize_s ? 32'h0 : DATA_W'($signed(value1_i) >>> amt_s);
      OP_LSR:  result_o = oversize_s ? 32'h0 : (value1_i >> amt_s);
      OP_LSL:  result_o = oversize_s ? 32'h0 : (value1_i << amt_s);
      OP_PASS: result_o = value1_i;
      default: result_o = value1_i;
    endcase
  end

endmodule

// File: rtl/shift_sched.sv
// Two-port round-robin scheduler in front of a shared shifter with a one-deep output register.
module shift_sched
  import shift_sched_pkg::*;
#(
  parameter int NPORT = shift_sched_pkg::NPORT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  shift_sched_if.slave bus
);

  logic [NPORT-1:0]  grant_s;
  logic              free_s;
  logic              any_grant_s;
  logic              sel_s;
  logic [DATA_W-1:0] core_result_s;

  logic              ptr_q;
  logic              rsp_valid_q;
  logic              rsp_port_q;
  logic [DATA_W-1:0] rsp_data_q;

  // Grant the favoured port if it asks, otherwise the other one; nothing while output is blocked.
  always_comb begin
    free_s  = !rsp_valid_q || bus.rsp_ready;
    grant_s = '0;
    if (rst_n && en && free_s) begin
      if (bus.req_valid[ptr_q]) begin
        grant_s[ptr_q] = 1'b1;
      end else if (bus.req_valid[~ptr_q]) begin
        grant_s[~ptr_q] = 1'b1;
      end else begin
        grant_s = '0;
      end
    end else begin
      grant_s = '0;
    end
    any_grant_s = |grant_s;
    sel_s       = grant_s[1];
  end

  shift_core u_core (
    .op_i     (op_e'(sel_s ? bus.req_op1 : bus.req_op0)),
    .value1_i (sel_s ? bus.req_value1_1 : bus.req_value1_0),
    .value2_i (sel_s ? bus.req_value2_1 : bus.req_value2_0),
    .hex_i    (sel_s ? bus.req_hex1 : bus.req_hex0),
    .result_o (core_result_s)
  );

  // Output register and priority pointer; a new grant overwrites a result being consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_port_q  <= 1'b0;
      rsp_data_q  <= 32'h0;
    end else if (any_grant_s) begin
      ptr_q       <= ~sel_s;
      rsp_valid_q <= 1'b1;
      rsp_port_q  <= sel_s;
      rsp_data_q  <= core_result_s;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_q;
    end
  end

  assign bus.req_ready = grant_s;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_port  = rsp_port_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: doc/shift_sched.md
SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 Parameter NPORT, default 2, meaning number of requesters sharing the shifter (fixed at 2 in this revision).
REQ-002 Port clk  input  1  single clock; all state on rising edge.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port en  input  1  grant enable; low blocks new grants, does not block output drain.
REQ-005 Port req_valid  input  2  per-port request valid.
REQ-006 Port req_ready  output  2  per-port grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-007 Port req_op0, req_op1  input  2 each  op: 00 ASR, 01 LSR, 10 LSL, 11 pass-through.
REQ-008 Port req_value1_0, req_value1_1  input  32 each  operand to shift.
REQ-009 Port req_value2_0, req_value2_1  input  32 each  register shift amount.
REQ-010 Port req_hex0, req_hex1  input  4 each  immediate shift offset.
REQ-011 Port rsp_valid  output  1  result valid.
REQ-012 Port rsp_ready  input  1  consumer accepts result.
REQ-013 Port rsp_port  output  1  index of the requester that owns the result.
REQ-014 Port rsp_data  output  32  shift result.

Function
REQ-015 Shift amount SHALL be 5 bits: value2[4:0]==0 gives hex+1, else value2[4:0]+hex, both modulo 32 (wrap, no saturation).
REQ-016 If any bit of value2[31:5] is set, result SHALL be 32'h0 for ASR, LSR and LSL.
REQ-017 Amount 0 SHALL return value1 unchanged; ASR SHALL fill with value1[31]; LSR and LSL SHALL fill with zeros.
REQ-018 Op 11 SHALL return value1 unchanged, ignoring value2 and hex.
REQ-019 Output register SHALL be able to load when rsp_valid is low or rsp_ready is high ("free").
REQ-020 At most one req_ready bit SHALL be high per cycle, and only when en is high and the output register is free.
REQ-021 Arbitration SHALL be round-robin: the priority pointer selects the favoured port; a lone valid port is granted regardless of the pointer.
REQ-022 After each grant the pointer SHALL move to the port that was not granted; with no grant it SHALL hold.
REQ-023 Latency SHALL be 1 cycle: a grant in cycle N gives rsp_valid, rsp_data and rsp_port in cycle N+1.
REQ-024 Throughput SHALL be 1 result per cycle when rsp_ready stays high.
REQ-025 When rsp_valid is high and rsp_ready is low, rsp_data and rsp_port SHALL hold stable and no grant SHALL issue.
REQ-026 If a result is consumed and a new grant occurs in the same cycle, the new result SHALL replace it with no bubble.
REQ-027 If en falls while rsp_valid is high, the held result SHALL still drain normally.

Reset
REQ-028 While rst_n is low: rsp_valid=0, rsp_data=0, rsp_port=0, pointer=port 0, req_ready=0.
REQ-029 Reset asserted mid-operation SHALL discard any held result without a handshake; the first cycle after release SHALL grant port 0 first.

Structure
REQ-030 A shared package SHALL hold the op encodings, NPORT, and the 5-bit shift-amount width constant.
REQ-031 The arithmetic of REQ-015 to REQ-018 SHALL be in one combinational sub-module, shift_core; shift_sched SHALL hold only the arbiter, pointer and output register.

Verification
REQ-032 Port0 ASR, value1=32'h8000_0000, value2=0, hex=0 -> next cycle rsp_data=32'hC000_0000, rsp_port=0.
REQ-033 Port1 LSR, value1=32'hF000_0000, value2=4, hex=3 -> rsp_data=32'h01E0_0000; port0 LSL, value1=1, value2=32'h20 -> rsp_data=0.
REQ-034 Port0 LSL, value2=31, hex=1 (amount wraps to 0), value1=32'h1234_5678 -> rsp_data=32'h1234_5678.
REQ-035 Both ports valid for 4 cycles, rsp_ready=1 -> grants alternate 0,1,0,1, and rsp_port follows the same order one cycle later.
REQ-036 rsp_ready=0 for 3 cycles while rsp_valid=1 -> req_ready=0 and rsp_data stable; rsp_ready rises -> grant in that same cycle.
REQ-037 rst_n pulsed low while rsp_valid=1 -> rsp_valid=0 immediately (asynchronously); after release, both ports valid -> port 0 granted first.
